// File: rtl/fp_int_mac_seq_ctrl.sv
// Sequencer feeding a bit-serial fp16 x int MAC, one dot product per start.
// Define MAC_DONE_TIMEOUT_EN to add a 255-cycle watchdog on mac_done.
module fp_int_mac_seq_ctrl #(
   parameter int ACT_WIDTH = 16,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] vec_len,
   input  logic [3:0]           precision,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [ACT_WIDTH-1:0] op_act,
   input  logic [7:0]           op_w,
   output logic                 mac_valid,
   output logic                 mac_set,
   output logic [ACT_WIDTH-1:0] mac_act,
   output logic                 mac_w,
   output logic [3:0]           mac_precision,
   output logic [4:0]           mac_exp_set,
   output logic [31:0]          mac_fixed_point_acc,
   input  logic                 mac_done,
   input  logic [4:0]           mac_exp_out,
   input  logic [ACC_WIDTH-1:0] mac_fixed_point_out,
   output logic                 busy,
   output logic                 res_valid,
   output logic [4:0]           res_exp,
   output logic [ACC_WIDTH-1:0] res_fixed,
   output logic                 err
);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, SHIFT, WAIT, DONE
   } state_t;

   state_t                 state_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   cnt_q;
   logic [LEN_WIDTH-1:0]   cnt_d;
   logic [3:0]             p_q;
   logic [7:0]             w_q;
   logic [ACT_WIDTH-1:0]   act_q;
   logic                   bit_q;
   logic [2:0]             k_q;
   logic [4:0]             exp_q;
   logic [31:0]            acc_q;
   logic                   err_q;
`ifdef MAC_DONE_TIMEOUT_EN
   logic [7:0]             wd_q;
`endif

   assign cnt_d = cnt_q + LEN_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         w_q     <= '0;
         act_q   <= '0;
         bit_q   <= 1'b0;
         k_q     <= '0;
         exp_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
`ifdef MAC_DONE_TIMEOUT_EN
         wd_q    <= '0;
`endif
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (precision != 4'd0 && precision <= 4'd8) begin
                     len_q   <= vec_len;
                     p_q     <= precision;
                     cnt_q   <= '0;
                     exp_q   <= '0;
                     acc_q   <= '0;
                     state_q <= (vec_len == '0) ? DONE : FETCH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (op_valid) begin
                  act_q   <= op_act;
                  w_q     <= op_w;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               k_q     <= '0;
               bit_q   <= w_q[0];
               state_q <= SHIFT;
            end
            SHIFT: begin
               // bit_q is staged one cycle ahead, LSB first
               if ({1'b0, k_q} == p_q - 4'd1) begin
                  state_q <= WAIT;
`ifdef MAC_DONE_TIMEOUT_EN
                  wd_q    <= '0;
`endif
               end else begin
                  k_q   <= k_q + 3'd1;
                  bit_q <= w_q[k_q + 3'd1];
               end
            end
            WAIT: begin
               if (mac_done) begin
                  exp_q   <= mac_exp_out;
                  acc_q   <= mac_fixed_point_out[31:0];
                  cnt_q   <= cnt_d;
                  state_q <= (cnt_d == len_q) ? DONE : FETCH;
               end
`ifdef MAC_DONE_TIMEOUT_EN
               else if (wd_q == 8'd254) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wd_q <= wd_q + 8'd1;
               end
`endif
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign op_ready            = (state_q == FETCH);
   assign mac_set             = (state_q == LOAD);
   assign mac_valid           = (state_q == SHIFT);
   assign res_valid           = (state_q == DONE);
   assign busy                = (state_q != IDLE);
   assign mac_act             = act_q;
   assign mac_w               = bit_q;
   assign mac_precision       = p_q;
   assign mac_exp_set         = exp_q;
   assign mac_fixed_point_acc = acc_q;
   assign res_exp             = exp_q;
   assign res_fixed           = ACC_WIDTH'(acc_q);
   assign err                 = err_q;

endmodule

// File: tb/tb_fp_int_mac_seq_ctrl.sv
// Scoreboard bench for fp_int_mac_seq_ctrl; the bench plays the MAC.
// MAC_DONE_TIMEOUT_EN selects the watchdog expectations.
module tb_fp_int_mac_seq_ctrl;
   localparam int AW = 16;
   localparam int CW = 32;
   localparam int LW = 8;

   logic          clk, rst, start;
   logic [LW-1:0] vec_len;
   logic [3:0]    precision;
   logic          op_valid, op_ready;
   logic [AW-1:0] op_act;
   logic [7:0]    op_w;
   logic          mac_valid, mac_set;
   logic [AW-1:0] mac_act;
   logic          mac_w;
   logic [3:0]    mac_precision;
   logic [4:0]    mac_exp_set;
   logic [31:0]   mac_fixed_point_acc;
   logic          mac_done;
   logic [4:0]    mac_exp_out;
   logic [CW-1:0] mac_fixed_point_out;
   logic          busy, res_valid;
   logic [4:0]    res_exp;
   logic [CW-1:0] res_fixed;
   logic          err;

   typedef struct packed {
      logic [AW-1:0] act;
      logic [4:0]    ex;
      logic [31:0]   acc;
   } set_t;
   typedef struct packed {
      logic [4:0]    ex;
      logic [CW-1:0] fix;
   } res_t;

   set_t set_q[$];
   logic bit_q[$];
   res_t res_q[$];
   set_t se;
   res_t re;
   logic eb;
   int   errors = 0;
   int   checks = 0;
   int   n_set = 0;
   int   n_valid = 0;
   int   n_res = 0;

   fp_int_mac_seq_ctrl #(
      .ACT_WIDTH(AW), .ACC_WIDTH(CW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .vec_len(vec_len), .precision(precision),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_act(op_act), .op_w(op_w),
      .mac_valid(mac_valid), .mac_set(mac_set),
      .mac_act(mac_act), .mac_w(mac_w),
      .mac_precision(mac_precision),
      .mac_exp_set(mac_exp_set),
      .mac_fixed_point_acc(mac_fixed_point_acc),
      .mac_done(mac_done), .mac_exp_out(mac_exp_out),
      .mac_fixed_point_out(mac_fixed_point_out),
      .busy(busy), .res_valid(res_valid),
      .res_exp(res_exp), .res_fixed(res_fixed),
      .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   // scoreboard: pops expectations as the DUT drives the MAC and results
   always @(negedge clk) begin
      if (rst) begin
         if (mac_set) begin
            n_set++;
            checks++;
            if (set_q.size() == 0) begin
               errors++;
               $display("FAIL mac_set_unexpected: got mac_set=1, required 0");
            end else begin
               se = set_q.pop_front();
               if ({mac_act, mac_exp_set, mac_fixed_point_acc} !== se) begin
                  errors++;
                  $display("FAIL mac_set_fields: got act=%h exp=%0d acc=%h, required act=%h exp=%0d acc=%h",
                           mac_act, mac_exp_set, mac_fixed_point_acc, se.act, se.ex, se.acc);
               end
            end
         end
         if (mac_valid) begin
            n_valid++;
            checks++;
            if (bit_q.size() == 0) begin
               errors++;
               $display("FAIL mac_valid_unexpected: got mac_valid=1, required 0");
            end else begin
               eb = bit_q.pop_front();
               if (mac_w !== eb) begin
                  errors++;
                  $display("FAIL mac_w_bit: got %b, required %b", mac_w, eb);
               end
            end
         end
         if (res_valid) begin
            n_res++;
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL res_valid_unexpected: got res_valid=1, required 0");
            end else begin
               re = res_q.pop_front();
               if ({res_exp, res_fixed} !== re) begin
                  errors++;
                  $display("FAIL result: got exp=%0d fixed=%h, required exp=%0d fixed=%h",
                           res_exp, res_fixed, re.ex, re.fix);
               end
            end
         end
      end
   end

   task automatic start_op(input logic [LW-1:0] len, input logic [3:0] p);
      @(posedge clk); #1;
      start = 1'b1; vec_len = len; precision = p;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Call at posedge+1 with the DUT in FETCH; lat=0 leaves it in WAIT.
   task automatic run_element(input logic [AW-1:0] act, input logic [7:0] w,
                              input int p, input int lat,
                              input logic [4:0] ein, input logic [31:0] ain,
                              input logic [4:0] eo, input logic [31:0] fo,
                              output bit ok, output bit fr);
      int i;
      int nv;
      ok = 1'b1;
      set_q.push_back({act, ein, ain});
      for (int k = 0; k < p; k++) bit_q.push_back(w[k]);
      op_valid = 1'b1; op_act = act; op_w = w;
      @(negedge clk);
      fr = op_ready;
      i = 0;
      while (!op_ready && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (!op_ready) ok = 1'b0;
      @(posedge clk); #1;
      op_valid = 1'b0;
      nv = 0;
      i = 0;
      while (i < 40) begin
         @(negedge clk);
         i++;
         if (mac_valid) nv++;
         else if (nv > 0) break;
      end
      if (nv == 0 || mac_valid) ok = 1'b0;
      if (lat > 0 && ok) begin
         repeat (lat) @(posedge clk);
         #1;
         mac_done = 1'b1; mac_exp_out = eo; mac_fixed_point_out = fo;
         @(posedge clk); #1;
         mac_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      bit ok, fr;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({busy, op_ready, mac_valid, mac_set, mac_act, mac_w, mac_precision,
              mac_exp_set, mac_fixed_point_acc, res_valid, res_exp, res_fixed, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b act=%h p=%0d acc=%h res=%b, required all 0",
                     busy, op_ready, mac_act, mac_precision, mac_fixed_point_acc, res_valid);
         end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_hold: got busy=%b, required 0", busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, op_ready, mac_precision} !== {1'b1, 1'b1, 4'd4}) begin
         errors++;
         $display("FAIL fetch_after_reset: got busy=%b rdy=%b p=%0d, required 1 1 4",
                  busy, op_ready, mac_precision);
      end
      @(posedge clk); #1;
      run_element(16'h3C00, 8'h05, 4, 1, 5'd0, 32'h0, 5'd10, 32'h20, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_elem0: got stuck, required progress"); end
      res_q.push_back({5'd12, 32'h55});
      run_element(16'h4000, 8'hFA, 4, 2, 5'd10, 32'h20, 5'd12, 32'h55, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_elem1: got stuck, required progress"); end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_vec_res: got res_valid=%b, required 1", res_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      bit ok, fr;
      int ns0, nv0;
      start_op(8'd1, 4'd4);
      ns0 = n_set; nv0 = n_valid;
      res_q.push_back({5'd15, 32'h100});
      run_element(16'h3E00, 8'h0B, 4, 3, 5'd0, 32'h0, 5'd15, 32'h100, ok, fr);
      checks++;
      if (!ok || n_set - ns0 != 1 || n_valid - nv0 != 4) begin
         errors++;
         $display("FAIL single_counts: got ok=%b sets=%0d valids=%0d, required 1 1 4",
                  ok, n_set - ns0, n_valid - nv0);
      end
      @(negedge clk);
      checks++;
      if ({res_valid, busy} !== 2'b11) begin
         errors++;
         $display("FAIL single_done: got res_valid=%b busy=%b, required 1 1", res_valid, busy);
      end
      @(negedge clk);
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL single_idle: got res_valid=%b busy=%b, required 0 0", res_valid, busy);
      end
   endtask

   task automatic test_multi();
      bit ok, fr;
      int nr0;
      logic [AW-1:0] acts[3] = '{16'h3C00, 16'hBC00, 16'h4200};
      logic [7:0]    ws[3]   = '{8'hA5, 8'h80, 8'h7F};
      logic [4:0]    eos[3]  = '{5'd3, 5'd17, 5'd30};
      logic [31:0]   fos[3]  = '{32'h11, 32'hDEAD_BEEF, 32'h8000_0001};
      int            lats[3] = '{1, 3, 2};
      logic [4:0]    ein;
      logic [31:0]   ain;
      nr0 = n_res;
      start_op(8'd3, 4'd8);
      ein = '0; ain = '0;
      for (int n = 0; n < 3; n++) begin
         if (n == 2) res_q.push_back({eos[2], fos[2]});
         run_element(acts[n], ws[n], 8, lats[n], ein, ain, eos[n], fos[n], ok, fr);
         checks++;
         if (!ok || !fr) begin
            errors++;
            $display("FAIL multi_elem%0d: got ok=%b first_ready=%b, required 1 1", n, ok, fr);
         end
         checks++;
         if (n < 2 && res_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_early_res%0d: got res_valid=%b, required 0", n, res_valid);
         end
         ein = eos[n]; ain = fos[n];
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (n_res - nr0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL multi_res_count: got %0d busy=%b, required 1 0", n_res - nr0, busy);
      end
   endtask

   task automatic test_bad_prec();
      logic [3:0] ps[2] = '{4'd0, 4'd9};
      for (int i = 0; i < 2; i++) begin
         start_op(8'd2, ps[i]);
         @(negedge clk);
         checks++;
         if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL bad_prec_err p=%0d: got err=%b busy=%b, required 1 0", ps[i], err, busy);
         end
         @(negedge clk);
         checks++;
         if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bad_prec_after p=%0d: got err=%b busy=%b, required 0 0", ps[i], err, busy);
         end
      end
   endtask

   task automatic test_zero_len();
      res_q.push_back({5'd0, 32'h0});
      start_op(8'd0, 4'd4);
      @(negedge clk);
      checks++;
      if ({res_valid, busy} !== 2'b11) begin
         errors++;
         $display("FAIL zero_len_res: got res_valid=%b busy=%b, required 1 1", res_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_idle: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_stall();
      bit ok, fr;
      int ns0;
      start_op(8'd1, 4'd2);
      ns0 = n_set;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         mac_done = 1'b1; mac_exp_out = 5'd31; mac_fixed_point_out = 32'hFFFF_FFFF;
         @(negedge clk);
         checks++;
         if ({op_ready, busy, mac_set} !== 3'b110) begin
            errors++;
            $display("FAIL stall_hold%0d: got rdy=%b busy=%b set=%b, required 1 1 0",
                     i, op_ready, busy, mac_set);
         end
      end
      @(posedge clk); #1;
      mac_done = 1'b0;
      checks++;
      if (n_set != ns0) begin
         errors++;
         $display("FAIL stall_set: got %0d sets, required 0", n_set - ns0);
      end
      res_q.push_back({5'd3, 32'h7});
      run_element(16'h5555, 8'h02, 2, 1, 5'd0, 32'h0, 5'd3, 32'h7, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_elem: got stuck, required progress"); end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int i;
      int nr0;
      nr0 = n_res;
      start_op(8'd1, 4'd4);
      set_q.push_back({16'h1234, 5'd0, 32'h0});
      for (int k = 0; k < 4; k++) bit_q.push_back(1'b1);
      op_valid = 1'b1; op_act = 16'h1234; op_w = 8'hFF;
      @(posedge clk); #1;
      op_valid = 1'b0;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!mac_valid && i < 10);
      checks++;
      if (mac_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_reach_shift: got mac_valid=%b, required 1", mac_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mac_valid, mac_set, busy, res_valid, mac_precision, mac_act} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b busy=%b res=%b p=%0d act=%h, required all 0",
                  mac_valid, busy, res_valid, mac_precision, mac_act);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (n_res != nr0 || busy !== 1'b0 || set_q.size() != 0) begin
         errors++;
         $display("FAIL mid_no_res: got res=%0d busy=%b sets_left=%0d, required 0 0 0",
                  n_res - nr0, busy, set_q.size());
      end
      bit_q.delete();
      set_q.delete();
   endtask

   task automatic test_wait_hold();
      bit ok, fr;
      int nr0;
      int n;
      nr0 = n_res;
      start_op(8'd1, 4'd3);
      run_element(16'h2222, 8'h05, 3, 0, 5'd0, 32'h0, 5'd0, 32'h0, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL wait_reach: got stuck, required WAIT"); end
`ifdef MAC_DONE_TIMEOUT_EN
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (err) break;
      end
      checks++;
      if (n != 255 || err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wd_timeout: got err after %0d cycles busy=%b, required 255 0", n, busy);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (err !== 1'b0 || n_res != nr0) begin
         errors++;
         $display("FAIL wd_after: got err=%b res=%0d, required 0 0", err, n_res - nr0);
      end
`else
      n = 0;
      repeat (1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({busy, op_ready, mac_valid, err} !== 4'b1000 || n_res != nr0) begin
         errors++;
         $display("FAIL wait_persist after %0d: got busy=%b rdy=%b err=%b, required 1 0 0",
                  n, busy, op_ready, err);
      end
      res_q.push_back({5'd7, 32'h1234});
      @(posedge clk); #1;
      mac_done = 1'b1; mac_exp_out = 5'd7; mac_fixed_point_out = 32'h1234;
      @(posedge clk); #1;
      mac_done = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_release: got res_valid=%b, required 1", res_valid);
      end
`endif
   endtask

   task automatic test_back_to_back();
      bit ok, fr;
      start_op(8'd2, 4'd1);
      run_element(16'h0001, 8'h01, 1, 1, 5'd0, 32'h0, 5'd1, 32'h2, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_a0: got stuck, required progress"); end
      res_q.push_back({5'd4, 32'h9});
      run_element(16'h0002, 8'h00, 1, 1, 5'd1, 32'h2, 5'd4, 32'h9, ok, fr);
      checks++;
      if (!ok || !fr) begin
         errors++;
         $display("FAIL b2b_a1: got ok=%b first_ready=%b, required 1 1", ok, fr);
      end
      @(negedge clk);
      start_op(8'd1, 4'd1);
      res_q.push_back({5'd9, 32'hABC});
      run_element(16'h0003, 8'h01, 1, 1, 5'd0, 32'h0, 5'd9, 32'hABC, ok, fr);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_b0: got stuck, required progress"); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (res_q.size() != 0 || bit_q.size() != 0 || set_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got res=%0d bits=%0d sets=%0d left, required 0",
                  res_q.size(), bit_q.size(), set_q.size());
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b1; vec_len = 8'd2; precision = 4'd4;
      op_valid = 1'b0; op_act = '0; op_w = '0;
      mac_done = 1'b0; mac_exp_out = '0; mac_fixed_point_out = '0;
      test_reset();
      test_single();
      test_multi();
      test_bad_prec();
      test_zero_len();
      test_stall();
      test_reset_mid();
      test_wait_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
